// File: rtl/sevenseg_scan_decoder.sv
// Recovers the hex nibble shown on each digit of a multiplexed, active-low seven-segment bus.
// Optional build macro SEVENSEG_ERR_COUNT_EN adds a saturating illegal-glyph counter (err_count).
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              segments,
    input  logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic [4*NUM_DIGITS-1:0] hex_value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic [2:0]              update_idx
`ifdef SEVENSEG_ERR_COUNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int            CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        GLYPH_HEX,
        GLYPH_BLANK,
        GLYPH_BAD
    } glyph_kind_e;

    typedef struct packed {
        glyph_kind_e kind;
        logic [3:0]  nibble;
    } glyph_t;

    function automatic glyph_t decode_glyph(input logic [6:0] seg);
        glyph_t g;
        g.kind   = GLYPH_HEX;
        g.nibble = 4'h0;
        case (seg)
            7'b1000000: g.nibble = 4'h0;
            7'b1111001: g.nibble = 4'h1;
            7'b0100100: g.nibble = 4'h2;
            7'b0110000: g.nibble = 4'h3;
            7'b0011001: g.nibble = 4'h4;
            7'b0010010: g.nibble = 4'h5;
            7'b0000010: g.nibble = 4'h6;
            7'b1111000: g.nibble = 4'h7;
            7'b0000000: g.nibble = 4'h8;
            7'b0011000: g.nibble = 4'h9;
            7'b0001000: g.nibble = 4'hA;
            7'b0000011: g.nibble = 4'hB;
            7'b0100111: g.nibble = 4'hC;
            7'b0100001: g.nibble = 4'hD;
            7'b0000110: g.nibble = 4'hE;
            7'b0001110: g.nibble = 4'hF;
            7'b1111111: g.kind   = GLYPH_BLANK;
            default:    g.kind   = GLYPH_BAD;
        endcase
        return g;
    endfunction

    // Lowest active (low) select bit; callers only use it when exactly one is low.
    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] sel_n);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!sel_n[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    primed;
    logic [CW-1:0]           stab_cnt;
    logic [CW-1:0]           cnt_next;
    logic                    cap_done;
    logic                    cap_done_next;
    logic                    in_match;
    logic                    sel_legal;
    logic                    capture;
    glyph_t                  glyph;
    logic [4*NUM_DIGITS-1:0] hex_next;
    logic [NUM_DIGITS-1:0]   valid_next;
    logic [NUM_DIGITS-1:0]   err_next;
    logic [2:0]              idx_next;

    // The first sample after reset counts as a change, so a fresh window always starts from zero.
    always_comb begin
        in_match = primed && (segments == seg_q) && (digit_sel_n == sel_q);
        if (!in_match) begin
            cnt_next = '0;
        end else if (stab_cnt == CNT_MAX) begin
            cnt_next = CNT_MAX;
        end else begin
            cnt_next = stab_cnt + 1'b1;
        end
        sel_legal     = $onehot(~sel_q);
        capture       = in_match && (cnt_next == CNT_MAX) && sel_legal && !cap_done;
        cap_done_next = in_match && (cap_done || capture);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        glyph      = decode_glyph(seg_q);
        hex_next   = hex_value;
        valid_next = digit_valid;
        err_next   = digit_err;
        idx_next   = update_idx;
        if (capture) begin
            idx_next = low_index(sel_q);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!sel_q[i]) begin
                    case (glyph.kind)
                        GLYPH_HEX: begin
                            hex_next[4*i +: 4] = glyph.nibble;
                            valid_next[i]      = 1'b1;
                            err_next[i]        = 1'b0;
                        end
                        GLYPH_BLANK: begin
                            valid_next[i] = 1'b0;
                            err_next[i]   = 1'b0;
                        end
                        default: begin
                            valid_next[i] = 1'b0;
                            err_next[i]   = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    // NOTE: the per-digit result bank is a flop array, not RAM, so it is cleared by reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q       <= '0;
            sel_q       <= '1;
            primed      <= 1'b0;
            stab_cnt    <= '0;
            cap_done    <= 1'b0;
            hex_value   <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            update      <= 1'b0;
            update_idx  <= 3'd0;
        end else begin
            seg_q       <= segments;
            sel_q       <= digit_sel_n;
            primed      <= 1'b1;
            stab_cnt    <= cnt_next;
            cap_done    <= cap_done_next;
            hex_value   <= hex_next;
            digit_valid <= valid_next;
            digit_err   <= err_next;
            update      <= capture;
            update_idx  <= idx_next;
        end
    end

`ifdef SEVENSEG_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'd0;
        end else if (capture && (glyph.kind == GLYPH_BAD) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: a decode model pushes expected captures to a queue,
// and each observed update pulse pops and compares one entry (edge, index, all digit state).
module tb_sevenseg_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    logic            clk;
    logic            reset_n;
    logic [6:0]      segments;
    logic [ND-1:0]   digit_sel_n;
    logic [4*ND-1:0] hex_value;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   digit_err;
    logic            update;
    logic [2:0]      update_idx;
`ifdef SEVENSEG_ERR_COUNT_EN
    logic [7:0]      err_count;
`endif

    sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .segments    (segments),
        .digit_sel_n (digit_sel_n),
        .hex_value   (hex_value),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update),
        .update_idx  (update_idx)
`ifdef SEVENSEG_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    typedef struct {
        int              edge_no;
        logic [2:0]      idx;
        logic [4*ND-1:0] hex;
        logic [ND-1:0]   valid;
        logic [ND-1:0]   err;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    int total    = 0;
    int bad      = 0;
    int edge_cnt = 0;
    int pulses   = 0;
    int p0;

    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_err;
    int              m_err_cnt;
    logic [ND-1:0]   prev_sel;
    logic [6:0]      prev_seg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample just after the edge and score any update pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (update === 1'b1) begin
            pulses++;
            check("update_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("capture_edge", 32'(edge_cnt), 32'(e.edge_no));
                check("update_idx", 32'(update_idx), 32'(e.idx));
                check("hex_value", 32'(hex_value), 32'(e.hex));
                check("digit_valid", 32'(digit_valid), 32'(e.valid));
                check("digit_err", 32'(digit_err), 32'(e.err));
            end
        end
    endtask

    // Drive a pattern for a number of cycles; predict a capture when a new legal dwell is long enough.
    task automatic dwell(input logic [ND-1:0] sel, input logic [6:0] seg, input int cycles);
        exp_t       e;
        int         idx;
        int         kind;
        logic [3:0] nib;
        digit_sel_n = sel;
        segments    = seg;
        if (({sel, seg} !== {prev_sel, prev_seg}) && (cycles >= S) && ($countones(~sel) == 1)) begin
            idx = 0;
            for (int i = ND - 1; i >= 0; i--) if (!sel[i]) idx = i;
            kind = 2;
            nib  = 4'h0;
            for (int k = 0; k < 16; k++) begin
                if (seg == glyph_tab[k]) begin
                    kind = 0;
                    nib  = 4'(k);
                end
            end
            if (seg == 7'h7F) kind = 1;
            case (kind)
                0: begin
                    m_hex[4*idx +: 4] = nib;
                    m_valid[idx]      = 1'b1;
                    m_err[idx]        = 1'b0;
                end
                1: begin
                    m_valid[idx] = 1'b0;
                    m_err[idx]   = 1'b0;
                end
                default: begin
                    m_valid[idx] = 1'b0;
                    m_err[idx]   = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
            endcase
            e.edge_no = edge_cnt + S;
            e.idx     = 3'(idx);
            e.hex     = m_hex;
            e.valid   = m_valid;
            e.err     = m_err;
            exp_q.push_back(e);
        end
        prev_sel = sel;
        prev_seg = seg;
        repeat (cycles) tick();
    endtask

    task automatic check_pending(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic model_clear();
        m_hex     = '0;
        m_valid   = '0;
        m_err     = '0;
        m_err_cnt = 0;
        prev_sel  = 'x;
        prev_seg  = 'x;
    endtask

    initial begin
        model_clear();
        reset_n     = 1'b1;
        segments    = 7'h7F;
        digit_sel_n = '1;
        #3 reset_n  = 1'b0;
        #1;
        check("rst_hex", 32'(hex_value), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_err", 32'(digit_err), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        check("rst_idx", 32'(update_idx), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Idle with no digit selected.
        dwell(4'b1111, 7'h7F, 100);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_hex", 32'(hex_value), 32'd0);
        check("idle_valid", 32'(digit_valid), 32'd0);
        check_pending("idle_pending");

        // Single capture on digit 0, then a long hold with no second pulse.
        p0 = pulses;
        dwell(4'b1110, 7'h30, 24);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        check("single_nibble", 32'(hex_value[3:0]), 32'h3);
        check("single_valid", 32'(digit_valid), 32'b0001);
        check_pending("single_pending");

        // Full scan of four digits.
        p0 = pulses;
        dwell(4'b1110, 7'h79, 6);
        dwell(4'b1101, 7'h08, 6);
        dwell(4'b1011, 7'h27, 6);
        dwell(4'b0111, 7'h0E, 6);
        dwell(4'b0111, 7'h0E, 5);
        check("scan_pulses", 32'(pulses - p0), 32'd4);
        check("scan_hex", 32'(hex_value), 32'hFCA1);
        check("scan_valid", 32'(digit_valid), 32'b1111);
        check("scan_idx_hold", 32'(update_idx), 32'd3);
        check_pending("scan_pending");

        // Short dwell then an illegal two-digit select.
        p0 = pulses;
        dwell(4'b1011, 7'h00, 3);
        dwell(4'b0011, 7'h00, 10);
        check("short_pulses", 32'(pulses - p0), 32'd0);
        check("short_hex", 32'(hex_value), 32'(m_hex));
        check("short_valid", 32'(digit_valid), 32'(m_valid));
        check("short_err", 32'(digit_err), 32'(m_err));
        check_pending("short_pending");

        // Blank, then an illegal glyph on digit 1.
        dwell(4'b1101, 7'h7F, 5);
        check("blank_valid1", 32'(digit_valid[1]), 32'd0);
        check("blank_err1", 32'(digit_err[1]), 32'd0);
        dwell(4'b1101, 7'h2A, 5);
        check("bad_err", 32'(digit_err), 32'b0010);
        check("bad_valid", 32'(digit_valid), 32'b1101);
        check("bad_hex1", 32'(hex_value[7:4]), 32'hA);
`ifdef SEVENSEG_ERR_COUNT_EN
        check("err_count_one", 32'(err_count), 32'd1);
        for (int i = 0; i < 300; i++) dwell(4'b1101, (i % 2 == 0) ? 7'h55 : 7'h2A, S);
        check("err_count_sat", 32'(err_count), 32'(m_err_cnt));
        check("err_count_255", 32'(err_count), 32'd255);
`endif
        check_pending("bad_pending");

        // Reset in the middle of a window; a full window is needed afterwards.
        digit_sel_n = 4'b0111;
        segments    = 7'h12;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_hex", 32'(hex_value), 32'd0);
        check("midrst_valid", 32'(digit_valid), 32'd0);
        check("midrst_err", 32'(digit_err), 32'd0);
        check("midrst_idx", 32'(update_idx), 32'd0);
`ifdef SEVENSEG_ERR_COUNT_EN
        check("midrst_err_count", 32'(err_count), 32'd0);
`endif
        model_clear();
        tick();
        reset_n = 1'b1;
        p0 = pulses;
        dwell(4'b0111, 7'h12, S + 4);
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        check("post_rst_hex", 32'(hex_value), 32'h5000);
        check_pending("final_pending");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive side of the team's hex-to-seven-segment encoding: snoops a multiplexed, active-low seven-segment display bus (segment lines plus per-digit selects) and recovers the hex nibble shown on each digit.
- Sits between the board display pins and self-check or readback logic, so displayed values can be compared against internal state.
- Filters scan glitches with a stability window and flags patterns that are not legal hex glyphs.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before capture (min 2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
segments  input  7  active-low segment lines, bit6=g ... bit0=a
digit_sel_n  input  NUM_DIGITS  active-low digit select; exactly one low = legal
hex_value  output  4*NUM_DIGITS  recovered nibbles; digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i set = hex_value digit i holds a legal capture
digit_err  output  NUM_DIGITS  bit i set = last capture on digit i was an illegal glyph
update  output  1  one-cycle pulse per capture
update_idx  output  3  digit index of the current capture, meaningful while update=1

Behaviour:
- Reset (async assert, sync deassert handled upstream): hex_value=0, digit_valid=0, digit_err=0, update=0, update_idx=0, stability counter=0, capture-done flag=0.
- Inputs registered once (seg_q, sel_q). Stability counter increments when {segments,digit_sel_n} equals {seg_q,sel_q}, saturates at STABLE_CYCLES-1, and clears to 0 on any difference.
- Capture fires on the edge where the counter equals STABLE_CYCLES-1, sel_q is one-hot-low, and the capture-done flag is clear. The capture sets the done flag. The done flag clears on any input change.
- Result: exactly one capture per stable dwell. Outputs are updated and update is pulsed on that edge.
- Latency: inputs constant from edge N give a capture at edge N+STABLE_CYCLES-1.
- Decode table (active-low pattern -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 0100111->C, 0100001->D, 0000110->E, 0001110->F.
- Capture outcomes for digit i:
  - Legal glyph: hex_value[i] is written; digit_valid[i]=1, digit_err[i]=0.
  - Blank 1111111: hex_value[i] is unchanged; digit_valid[i]=0, digit_err[i]=0. update is pulsed.
  - Any other pattern: hex_value[i] is unchanged; digit_valid[i]=0, digit_err[i]=1. update is pulsed.
- digit_sel_n all high or with more than one bit low: no capture. The counter still runs but the capture is suppressed; no state changes.
- Digit select change mid-window restarts the window. A partial window never captures.
- Only the captured digit's bits change. The other digits hold their values.
- update_idx is the binary index of the low bit of sel_q. It holds its value between pulses.
- Reset mid-window: all state is cleared immediately; the next capture needs a full new window.

Optional Feature:
SEVENSEG_ERR_COUNT_EN
- Defined: adds output err_count [7:0]. It increments on each illegal-glyph capture, saturates at 255, and is reset to 0 by reset_n.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle with all selects high -> all outputs 0, no update pulse for 100 cycles.
- digit_sel_n=1110, segments=0110000 held 4 cycles -> one update pulse on the 4th edge, update_idx=0, hex_value[3:0]=3, digit_valid=0001. No second pulse while the inputs are held 20 more cycles.
- Scan digits 0..3 with glyphs 1,A,C,F (6-cycle dwell each) -> hex_value=16'hFCA1, digit_valid=1111, four update pulses with update_idx 0,1,2,3.
- Dwell of 3 cycles on digit 2 (below window), then digit_sel_n=0011 (two low) for 10 cycles -> no capture, outputs unchanged.
- Digit 1 shows 1111111 then 0101010 -> first capture: digit_valid[1]=0, digit_err[1]=0; second capture: digit_err[1]=1, hex_value[7:4] unchanged. With SEVENSEG_ERR_COUNT_EN: err_count=1; after 300 illegal captures err_count=255.
- reset_n pulsed low at cycle 2 of a 4-cycle window -> no capture; a capture follows only after 4 full stable cycles after release.
